avaliador_atualizacoes: RTL and testbench

Receiving end of the update-command handshake driven by the write orderer. The block accepts one update command (up to NUM_READ_PORTS neighbour candidates plus a predecessor address), latches it, and serially performs a read-compare-write on the distance memory for each valid neighbour. Each improved neighbour is pushed into the active list. A one-cycle ready pulse then releases the orderer for the next command.

---
 rtl/avaliador_atualizacoes.sv | 120 ++++++++++++
 tb/tb_avaliador_atualizacoes.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/avaliador_atualizacoes.sv
// avaliador_atualizacoes: serial read-compare-write of one update command's neighbours into the distance memory
module avaliador_atualizacoes #(
  parameter int ADDR_WIDTH = 10,
  parameter int DISTANCIA_WIDTH = 6,
  parameter int NUM_READ_PORTS = 8,
  parameter int CUSTO_WIDTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  oe_atualizar_in,
  input  logic [NUM_READ_PORTS-1:0]             oe_vizinho_valido_in,
  input  logic [ADDR_WIDTH*NUM_READ_PORTS-1:0]  oe_endereco_in,
  input  logic [CUSTO_WIDTH*NUM_READ_PORTS-1:0] oe_menor_vizinho_in,
  input  logic [DISTANCIA_WIDTH*NUM_READ_PORTS-1:0] oe_distancia_in,
  input  logic [ADDR_WIDTH-1:0]                 oe_anterior_in,
  output logic                                  aa_atualizar_ready_out,
  output logic                                  aa_ocupado_out,
  output logic                                  mem_rd_en_out,
  output logic [ADDR_WIDTH-1:0]                 mem_rd_addr_out,
  input  logic [DISTANCIA_WIDTH-1:0]            mem_rd_distancia_in,
  input  logic                                  mem_rd_valido_in,
  output logic                                  mem_wr_en_out,
  output logic [ADDR_WIDTH-1:0]                 mem_wr_addr_out,
  output logic [DISTANCIA_WIDTH-1:0]            mem_wr_distancia_out,
  output logic [ADDR_WIDTH-1:0]                 mem_wr_anterior_out,
  output logic                                  ativo_push_out,
  output logic [ADDR_WIDTH-1:0]                 ativo_endereco_out,
  output logic [CUSTO_WIDTH-1:0]                ativo_custo_out,
  input  logic                                  ativo_cheio_in,
  output logic                                  erro_out
);
  localparam int IW = $clog2(NUM_READ_PORTS);
  typedef enum logic [1:0] {IDLE, LER, COMPARAR, FIM} estado_t;
  estado_t estado;
  logic [IW-1:0] indice;
  logic [NUM_READ_PORTS-1:0] valido_q;
  logic [ADDR_WIDTH*NUM_READ_PORTS-1:0] endereco_q;
  logic [CUSTO_WIDTH*NUM_READ_PORTS-1:0] custo_q;
  logic [DISTANCIA_WIDTH*NUM_READ_PORTS-1:0] distancia_q;
  logic [ADDR_WIDTH-1:0] anterior_q;
  logic primeiro, lida_valida_q, erro;
  logic [DISTANCIA_WIDTH-1:0] lida_q, candidato, lida;
  logic [IW:0] inicial, proximo;
  logic lida_valida, atualiza, grava;

  // {found, index} of the lowest set bit
  function automatic logic [IW:0] menor_slot(input logic [NUM_READ_PORTS-1:0] m);
    menor_slot = '0;
    for (int i = NUM_READ_PORTS - 1; i >= 0; i--)
      if (m[i]) menor_slot = {1'b1, IW'(i)};
  endfunction

  assign inicial = menor_slot(oe_vizinho_valido_in);
  assign proximo = menor_slot(valido_q & ~((NUM_READ_PORTS'(2) << indice) - NUM_READ_PORTS'(1)));
  assign candidato = distancia_q[DISTANCIA_WIDTH*indice +: DISTANCIA_WIDTH];
  // live read data on the first compare cycle, the captured copy while stalled
  assign lida = primeiro ? mem_rd_distancia_in : lida_q;
  assign lida_valida = primeiro ? mem_rd_valido_in : lida_valida_q;
  assign atualiza = !lida_valida || candidato < lida;
  assign grava = estado == COMPARAR && atualiza && !ativo_cheio_in;

  assign aa_atualizar_ready_out = estado == FIM;
  assign aa_ocupado_out = estado != IDLE;
  assign mem_rd_en_out = estado == LER;
  assign mem_rd_addr_out = endereco_q[ADDR_WIDTH*indice +: ADDR_WIDTH];
  assign mem_wr_en_out = grava;
  assign mem_wr_addr_out = mem_rd_addr_out;
  assign mem_wr_distancia_out = candidato;
  assign mem_wr_anterior_out = anterior_q;
  assign ativo_push_out = grava;
  assign ativo_endereco_out = mem_rd_addr_out;
  assign ativo_custo_out = custo_q[CUSTO_WIDTH*indice +: CUSTO_WIDTH];
  assign erro_out = erro;

  // command latch, slot walk and sticky protocol error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= IDLE;
      indice <= '0;
      valido_q <= '0;
      endereco_q <= '0;
      custo_q <= '0;
      distancia_q <= '0;
      anterior_q <= '0;
      primeiro <= 1'b0;
      lida_q <= '0;
      lida_valida_q <= 1'b0;
      erro <= 1'b0;
    end else begin
      if (oe_atualizar_in && estado != IDLE) erro <= 1'b1;
      primeiro <= 1'b0;
      case (estado)
        IDLE: if (oe_atualizar_in) begin
          valido_q <= oe_vizinho_valido_in;
          endereco_q <= oe_endereco_in;
          custo_q <= oe_menor_vizinho_in;
          distancia_q <= oe_distancia_in;
          anterior_q <= oe_anterior_in;
          indice <= inicial[IW-1:0];
          estado <= inicial[IW] ? LER : FIM;
        end
        LER: begin
          primeiro <= 1'b1;
          estado <= COMPARAR;
        end
        COMPARAR: begin
          if (primeiro) begin
            lida_q <= mem_rd_distancia_in;
            lida_valida_q <= mem_rd_valido_in;
          end
          if (!(atualiza && ativo_cheio_in)) begin
            if (proximo[IW]) indice <= proximo[IW-1:0];
            estado <= proximo[IW] ? LER : FIM;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avaliador_atualizacoes.sv
// tb_avaliador_atualizacoes: directed vectors against a behavioural distance memory
module tb_avaliador_atualizacoes;
  localparam int AW = 10, DW = 6, NR = 8, CW = 4;
  logic clk = 0, rst_n = 1, strobe = 0, cheio = 0;
  logic [NR-1:0] mask = '0;
  logic [AW*NR-1:0] abus = '0;
  logic [CW*NR-1:0] kbus = '0;
  logic [DW*NR-1:0] dbus = '0;
  logic [AW-1:0] ant = '0;
  logic ready, busy, rd_en, wr_en, push, erro, rd_val;
  logic [AW-1:0] rd_addr, wr_addr, wr_ant, p_addr;
  logic [DW-1:0] rd_dist, wr_dist;
  logic [CW-1:0] p_cost;
  logic [DW-1:0] mem_d [1024];
  logic mem_v [1024];
  logic clr = 0, pre_en = 0, pre_v = 0;
  logic [AW-1:0] pre_a = '0;
  logic [DW-1:0] pre_d = '0;

  typedef struct {
    logic [NR-1:0] m; int sa, sb; logic [AW-1:0] aa, ab; logic [DW-1:0] ca, cb; logic [CW-1:0] ka, kb;
    logic [AW-1:0] an; logic pe; logic [AW-1:0] pa; logic [DW-1:0] pd; logic pv;
    int rdy, nrd, nwr;
    int c0; logic [AW-1:0] a0; logic [DW-1:0] d0; logic [CW-1:0] k0;
    int c1; logic [AW-1:0] a1; logic [DW-1:0] d1; logic [CW-1:0] k1;
  } vec_t;
  typedef struct {
    int c; logic [AW-1:0] a; logic [DW-1:0] d; logic [AW-1:0] an; logic [CW-1:0] k; logic wr, pu; logic [AW-1:0] pa;
  } ev_t;

  int checks = 0, fails = 0;
  ev_t evs[$];
  vec_t v[8];

  always #5 clk = ~clk;

  avaliador_atualizacoes dut (
    .clk(clk), .rst_n(rst_n), .oe_atualizar_in(strobe), .oe_vizinho_valido_in(mask),
    .oe_endereco_in(abus), .oe_menor_vizinho_in(kbus), .oe_distancia_in(dbus), .oe_anterior_in(ant),
    .aa_atualizar_ready_out(ready), .aa_ocupado_out(busy), .mem_rd_en_out(rd_en), .mem_rd_addr_out(rd_addr),
    .mem_rd_distancia_in(rd_dist), .mem_rd_valido_in(rd_val), .mem_wr_en_out(wr_en), .mem_wr_addr_out(wr_addr),
    .mem_wr_distancia_out(wr_dist), .mem_wr_anterior_out(wr_ant), .ativo_push_out(push),
    .ativo_endereco_out(p_addr), .ativo_custo_out(p_cost), .ativo_cheio_in(cheio), .erro_out(erro)
  );

  // read data valid one cycle after the strobe; other cycles return "valid, 0" so a missing capture shows up
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 1024; i++) begin mem_d[i] <= '0; mem_v[i] <= 1'b0; end
    else if (pre_en) begin mem_d[pre_a] <= pre_d; mem_v[pre_a] <= pre_v; end
    if (wr_en) begin mem_d[wr_addr] <= wr_dist; mem_v[wr_addr] <= 1'b1; end
    rd_dist <= rd_en ? mem_d[rd_addr] : '0;
    rd_val <= rd_en ? mem_v[rd_addr] : 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return 64'({ready, busy, rd_en, rd_addr, wr_en, wr_addr, wr_dist, wr_ant, push, p_addr, p_cost, erro});
  endfunction

  task automatic prep(input logic pe, input logic [AW-1:0] pa, input logic [DW-1:0] pd, input logic pv);
    @(negedge clk) clr = 1;
    @(negedge clk) begin clr = 0; pre_en = pe; pre_a = pa; pre_d = pd; pre_v = pv; end
    @(negedge clk) pre_en = 0;
  endtask

  task automatic start_cmd(input logic [NR-1:0] m, input logic [AW*NR-1:0] a, input logic [DW*NR-1:0] d,
                           input logic [CW*NR-1:0] k, input logic [AW-1:0] an);
    mask = m; abus = a; dbus = d; kbus = k; ant = an; strobe = 1;
  endtask

  // cycle n is the one following the n-th edge after acceptance
  task automatic watch(input int inj_n, input int cheio_until, output int rdy, output int nrd, output int bad);
    rdy = -1; nrd = 0; bad = 0;
    evs.delete();
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        strobe = 0; mask = 8'hff; ant = 10'($urandom());
        abus = 80'({$urandom(), $urandom(), $urandom()});
        dbus = 48'({$urandom(), $urandom()});
        kbus = $urandom();
      end
      if (n == inj_n) begin strobe = 1; mask = 8'h01; abus = 80'd100; dbus = 48'd1; kbus = '0; ant = 10'd500; end
      if (n == inj_n + 1) strobe = 0;
      cheio = n < cheio_until;
      @(negedge clk);
      if (wr_en || push) evs.push_back('{n, wr_addr, wr_dist, wr_ant, p_cost, wr_en, push, p_addr});
      if (rd_en) nrd++;
      if (rdy < 0 && ready) rdy = n;
      if ((rdy < 0 || n == rdy) != busy) bad++;
      if (rdy >= 0 && n == rdy + 1) begin
        if (ready) bad++;
        break;
      end
    end
  endtask

  task automatic check_ev(input string t, input int i, input int c, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [AW-1:0] an, input logic [CW-1:0] k);
    if (i < evs.size()) begin
      chk($sformatf("%s ev%0d cycle", t, i), evs[i].c, c);
      chk($sformatf("%s ev%0d wr_addr", t, i), evs[i].a, a);
      chk($sformatf("%s ev%0d wr_dist", t, i), evs[i].d, d);
      chk($sformatf("%s ev%0d wr_ant", t, i), evs[i].an, an);
      chk($sformatf("%s ev%0d cost", t, i), evs[i].k, k);
      chk($sformatf("%s ev%0d wr_en", t, i), evs[i].wr, 1);
      chk($sformatf("%s ev%0d push", t, i), evs[i].pu, 1);
      chk($sformatf("%s ev%0d push_addr", t, i), evs[i].pa, a);
    end
  endtask

  initial begin
    int rdy, nrd, bad, nr, nw;
    logic [AW*NR-1:0] a;
    logic [DW*NR-1:0] d;
    logic [CW*NR-1:0] k;
    v[0] = '{8'b00000101, 0, 2, 5, 9, 3, 7, 1, 2, 2, 0, 0, 0, 0, 5, 2, 2, 2, 5, 3, 1, 4, 9, 7, 2};
    v[1] = '{8'b00000001, 0, 1, 5, 100, 4, 0, 3, 9, 7, 1, 5, 4, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[2] = '{8'b00000001, 0, 1, 5, 100, 3, 0, 3, 9, 7, 1, 5, 4, 1, 3, 1, 1, 2, 5, 3, 3, 0, 0, 0, 0};
    v[3] = '{8'b00000000, 0, 1, 5, 6, 1, 2, 1, 2, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[4] = '{8'b00001010, 1, 3, 7, 7, 5, 6, 4, 5, 11, 0, 0, 0, 0, 5, 2, 1, 2, 7, 5, 4, 0, 0, 0, 0};
    v[5] = '{8'b10000000, 7, 0, 1023, 1, 63, 0, 15, 1, 1023, 1, 1023, 0, 0, 3, 1, 1, 2, 1023, 63, 15, 0, 0, 0, 0};
    v[6] = '{8'b01000010, 1, 6, 3, 4, 10, 0, 6, 7, 0, 1, 3, 20, 1, 5, 2, 2, 2, 3, 10, 6, 4, 4, 0, 7};
    v[7] = '{8'b00000001, 0, 5, 3, 8, 32, 1, 2, 2, 1, 1, 3, 31, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    #2 rst_n = 0;
    clr = 1;
    repeat (3) @(posedge clk);
    #1 chk("reset outputs", all_out(), 0);
    clr = 0;
    @(negedge clk) rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      prep(v[i].pe, v[i].pa, v[i].pd, v[i].pv);
      a = '0; d = '0; k = '0;
      a[AW*v[i].sb +: AW] = v[i].ab; d[DW*v[i].sb +: DW] = v[i].cb; k[CW*v[i].sb +: CW] = v[i].kb;
      a[AW*v[i].sa +: AW] = v[i].aa; d[DW*v[i].sa +: DW] = v[i].ca; k[CW*v[i].sa +: CW] = v[i].ka;
      start_cmd(v[i].m, a, d, k, v[i].an);
      watch(0, 0, rdy, nrd, bad);
      chk($sformatf("v%0d ready cycle", i), rdy, v[i].rdy);
      chk($sformatf("v%0d reads", i), nrd, v[i].nrd);
      chk($sformatf("v%0d writes", i), evs.size(), v[i].nwr);
      chk($sformatf("v%0d busy/ready shape", i), bad, 0);
      if (v[i].nwr > 0) check_ev($sformatf("v%0d", i), 0, v[i].c0, v[i].a0, v[i].d0, v[i].an, v[i].k0);
      if (v[i].nwr > 1) check_ev($sformatf("v%0d", i), 1, v[i].c1, v[i].a1, v[i].d1, v[i].an, v[i].k1);
    end
    chk("erro quiet", erro, 0);

    prep(0, 0, 0, 0);
    cheio = 1;
    start_cmd(8'h01, 80'd12, 48'd5, 32'd3, 10'd33);
    watch(0, 5, rdy, nrd, bad);
    chk("stall ready cycle", rdy, 6);
    chk("stall reads", nrd, 1);
    chk("stall writes", evs.size(), 1);
    chk("stall busy/ready shape", bad, 0);
    check_ev("stall", 0, 5, 12, 5, 33, 3);

    prep(0, 0, 0, 0);
    start_cmd(8'b00000101, 80'd5 | (80'd9 << 20), 48'd3 | (48'd7 << 12), 32'd1 | (32'd2 << 8), 10'd2);
    watch(2, 0, rdy, nrd, bad);
    chk("busy strobe erro", erro, 1);
    chk("busy strobe ready cycle", rdy, 5);
    chk("busy strobe reads", nrd, 2);
    chk("busy strobe writes", evs.size(), 2);
    check_ev("busy strobe", 0, 2, 5, 3, 2, 1);
    check_ev("busy strobe", 1, 4, 9, 7, 2, 2);

    prep(0, 0, 0, 0);
    start_cmd(8'b00000101, 80'd5 | (80'd9 << 20), 48'd3 | (48'd7 << 12), 32'd1 | (32'd2 << 8), 10'd2);
    @(posedge clk); #1 strobe = 0;
    @(posedge clk); #1;
    chk("pre-reset write pending", wr_en, 1);
    rst_n = 0;
    #1 chk("mid-command reset outputs", all_out(), 0);
    @(negedge clk) rst_n = 1;
    nr = 0; nw = 0;
    repeat (8) @(negedge clk) begin
      if (ready) nr++;
      if (wr_en || push) nw++;
    end
    chk("post-reset ready pulses", nr, 0);
    chk("post-reset writes", nw, 0);
    chk("dropped write absent", mem_v[5], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
